tree_path_scorer: RTL and testbench
===================================

TREE_PATH_SCORER -- requirements
Module: tree_path_scorer

Interface
REQ-001 Parameter DATA_WIDTH, default 8, width of sensor sample and node thresholds.
REQ-002 Parameter NODE_AW, default 4, node-table address width (2^NODE_AW nodes).
REQ-003 Parameter MAX_DEPTH, default 7, traversal depth limit.
REQ-004 Parameter ANOMALY_DEPTH, default 3, path lengths strictly below this are anomalous.
REQ-005 One clock; reset is synchronous and active-high.
REQ-006 clk  in  1  rising-edge clock.
REQ-007 reset  in  1  synchronous active-high reset.
REQ-008 data_input  in  DATA_WIDTH  sample from upstream input buffer.
REQ-009 data_ready  in  1  upstream sample valid, level, held until data_processed seen.
REQ-010 data_processed  out  1  one-cycle acknowledge of accepted sample.
REQ-011 cfg_we  in  1  node-table write strobe.
REQ-012 cfg_addr  in  NODE_AW  node index written.
REQ-013 cfg_threshold  in  DATA_WIDTH  node split threshold.
REQ-014 cfg_left, cfg_right  in  NODE_AW each  child indices.
REQ-015 cfg_leaf  in  1  node is leaf.
REQ-016 path_length  out  4  depth at which traversal ended.
REQ-017 anomaly  out  1  path_length < ANOMALY_DEPTH.
REQ-018 depth_limit  out  1  traversal ended by MAX_DEPTH, not a leaf.
REQ-019 score_valid  out  1  one-cycle pulse, path_length/anomaly/depth_limit updated.

Function
REQ-020 FSM states IDLE, WALK, DONE; reset state IDLE.
REQ-021 IDLE with data_ready=1 at an edge: latch data_input, node<=0, depth<=0, data_processed<=1, ->WALK.
REQ-022 data_processed deasserts on the next edge; never high two consecutive cycles.
REQ-023 data_ready ignored in WALK and DONE; no sample lost or double-accepted.
REQ-024 WALK, per edge, reads node[cur]: leaf -> path_length<=depth, depth_limit<=0, ->DONE.
REQ-025 WALK, internal node: sample < threshold -> cur<=left, else (incl. equal) cur<=right; depth<=depth+1.
REQ-026 WALK, internal node with depth==MAX_DEPTH: path_length<=MAX_DEPTH, depth_limit<=1, ->DONE.
REQ-027 DONE: score_valid<=1 for one cycle, anomaly<=(path_length<ANOMALY_DEPTH), ->IDLE.
REQ-028 Latency: leaf at depth d gives score_valid on the (d+2)th edge after accepting edge.
REQ-029 Unsigned comparison, full DATA_WIDTH; depth counter 4 bits, never wraps (MAX_DEPTH<=15).
REQ-030 cfg_we applied only in IDLE; writes in WALK/DONE discarded; write and accept in same IDLE edge: write applied, traversal reads updated table.
REQ-031 path_length, anomaly, depth_limit hold between score_valid pulses.
REQ-032 Node table has no reset; contents persist across reset.

Reset
REQ-033 reset=1 at an edge: state IDLE; data_processed, score_valid, anomaly, depth_limit, path_length <= 0.
REQ-034 reset mid-WALK aborts traversal; no score_valid for aborted sample; next data_ready accepted normally.
REQ-035 reset has priority over data_ready and cfg_we in the same edge.

Verification
REQ-036 Table: n0 thr 0x80 L1 R2; n1 leaf; n2 thr 0xC0 L3 R4; n3 leaf; n4 thr 0xF0 L5 R6; n5,n6 leaf. Sample 0x10 -> path_length 1, anomaly 1, score_valid 3 edges after accept.
REQ-037 Same table, sample 0xF8 -> path_length 3, anomaly 0, depth_limit 0; sample 0x80 -> right branch, 0x80<0xC0 -> n3, path_length 2, anomaly 1.
REQ-038 n0 R7, n7 internal L7 R7; sample 0x90 -> path_length 7, depth_limit 1, anomaly 0.
REQ-039 reset pulsed during WALK for 0xF8 -> no score_valid, outputs 0; next sample 0x10 scores path_length 1.
REQ-040 cfg_we to n1 (leaf->internal) while WALK -> ignored, result unchanged; data_ready held high through WALK -> exactly one data_processed pulse.
REQ-041 Drive via the serial input buffer upstream: bits 11010101 (0xD5) -> n0->n2->n4, 0xD5<0xF0 -> n5, path_length 3, anomaly 0.

Source files
------------

// File: rtl/tree_path_scorer.sv
// Isolation-tree path scorer: walks a programmable node table
// with one sample and reports the path length at which it stopped.
module tree_path_scorer #(
  parameter int DATA_WIDTH    = 8,
  parameter int NODE_AW       = 4,
  parameter int MAX_DEPTH     = 7,
  parameter int ANOMALY_DEPTH = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] data_input,
  input  logic                  data_ready,
  output logic                  data_processed,
  input  logic                  cfg_we,
  input  logic [NODE_AW-1:0]    cfg_addr,
  input  logic [DATA_WIDTH-1:0] cfg_threshold,
  input  logic [NODE_AW-1:0]    cfg_left,
  input  logic [NODE_AW-1:0]    cfg_right,
  input  logic                  cfg_leaf,
  output logic [3:0]            path_length,
  output logic                  anomaly,
  output logic                  depth_limit,
  output logic                  score_valid
);

  localparam int NODES = 1 << NODE_AW;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WALK = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [3:0] MAX_D = 4'(MAX_DEPTH);
  localparam logic [4:0] ANOM_D = 5'(ANOMALY_DEPTH);

  logic [DATA_WIDTH-1:0] thr_mem   [NODES];
  logic [NODE_AW-1:0]    left_mem  [NODES];
  logic [NODE_AW-1:0]    right_mem [NODES];
  logic                  leaf_mem  [NODES];

  logic [1:0]            state;
  logic [DATA_WIDTH-1:0] sample;
  logic [NODE_AW-1:0]    cur;
  logic [3:0]            depth;

  logic [DATA_WIDTH-1:0] nd_thr;
  logic [NODE_AW-1:0]    nd_left;
  logic [NODE_AW-1:0]    nd_right;
  logic                  nd_leaf;
  logic                  cfg_ok;

  assign nd_thr   = thr_mem[cur];
  assign nd_left  = left_mem[cur];
  assign nd_right = right_mem[cur];
  assign nd_leaf  = leaf_mem[cur];

  // Table is frozen while a sample is in flight.
  assign cfg_ok = cfg_we && (state == IDLE) && !reset;

  always_ff @(posedge clk) begin
    if (cfg_ok) begin
      thr_mem[cfg_addr]   <= cfg_threshold;
      left_mem[cfg_addr]  <= cfg_left;
      right_mem[cfg_addr] <= cfg_right;
      leaf_mem[cfg_addr]  <= cfg_leaf;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      data_processed <= 1'b0;
      score_valid    <= 1'b0;
      anomaly        <= 1'b0;
      depth_limit    <= 1'b0;
      path_length    <= 4'd0;
      cur            <= '0;
      depth          <= 4'd0;
      sample         <= '0;
    end else begin
      data_processed <= 1'b0;
      score_valid    <= 1'b0;
      unique case (state)
        IDLE: begin
          if (data_ready) begin
            sample         <= data_input;
            cur            <= '0;
            depth          <= 4'd0;
            data_processed <= 1'b1;
            state          <= WALK;
          end
        end
        WALK: begin
          if (nd_leaf) begin
            path_length <= depth;
            depth_limit <= 1'b0;
            state       <= DONE;
          end else if (depth == MAX_D) begin
            path_length <= MAX_D;
            depth_limit <= 1'b1;
            state       <= DONE;
          end else begin
            cur   <= (sample < nd_thr) ? nd_left : nd_right;
            depth <= depth + 4'd1;
          end
        end
        DONE: begin
          score_valid <= 1'b1;
          anomaly     <= ({1'b0, path_length} < ANOM_D);
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tree_path_scorer.sv
// Self-checking bench for tree_path_scorer against a
// path-walking reference model of the node table.
module tb_tree_path_scorer;

  localparam int DW = 8;
  localparam int AW = 4;
  localparam int MAXD = 7;
  localparam int ANOMD = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] data_input;
  logic          data_ready;
  logic          data_processed;
  logic          cfg_we;
  logic [AW-1:0] cfg_addr;
  logic [DW-1:0] cfg_threshold;
  logic [AW-1:0] cfg_left;
  logic [AW-1:0] cfg_right;
  logic          cfg_leaf;
  logic [3:0]    path_length;
  logic          anomaly;
  logic          depth_limit;
  logic          score_valid;

  int checks = 0;
  int failures = 0;

  logic [DW-1:0] m_thr   [16];
  logic [AW-1:0] m_left  [16];
  logic [AW-1:0] m_right [16];
  logic          m_leaf  [16];

  tree_path_scorer #(
    .DATA_WIDTH(DW), .NODE_AW(AW),
    .MAX_DEPTH(MAXD), .ANOMALY_DEPTH(ANOMD)
  ) dut (
    .clk(clk), .reset(reset),
    .data_input(data_input),
    .data_ready(data_ready),
    .data_processed(data_processed),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_threshold(cfg_threshold),
    .cfg_left(cfg_left), .cfg_right(cfg_right),
    .cfg_leaf(cfg_leaf),
    .path_length(path_length),
    .anomaly(anomaly),
    .depth_limit(depth_limit),
    .score_valid(score_valid)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Walk the tree as described: stop at a leaf or at the depth cap.
  function automatic void ref_walk(
    input  logic [DW-1:0] s,
    output int            pl,
    output logic          dl
  );
    int n = 0;
    pl = 0;
    dl = 1'b0;
    for (int d = 0; d <= MAXD; d++) begin
      if (m_leaf[n]) begin
        pl = d;
        return;
      end
      if (d == MAXD) begin
        pl = MAXD;
        dl = 1'b1;
        return;
      end
      n = (s < m_thr[n]) ? int'(m_left[n]) : int'(m_right[n]);
    end
  endfunction

  // Stage a table write; it lands on the next edge if the DUT is idle.
  task automatic stage_node(input int a, input int t,
                            input int l, input int r,
                            input bit lf);
    cfg_we        = 1'b1;
    cfg_addr      = AW'(a);
    cfg_threshold = DW'(t);
    cfg_left      = AW'(l);
    cfg_right     = AW'(r);
    cfg_leaf      = lf;
    m_thr[a]   = DW'(t);
    m_left[a]  = AW'(l);
    m_right[a] = AW'(r);
    m_leaf[a]  = lf;
  endtask

  task automatic write_node(input int a, input int t,
                            input int l, input int r,
                            input bit lf);
    stage_node(a, t, l, r, lf);
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic load_std_table();
    write_node(0, 8'h80, 1, 2, 0);
    write_node(1, 0, 0, 0, 1);
    write_node(2, 8'hC0, 3, 4, 0);
    write_node(3, 0, 0, 0, 1);
    write_node(4, 8'hF0, 5, 6, 0);
    write_node(5, 0, 0, 0, 1);
    write_node(6, 0, 0, 0, 1);
  endtask

  // Present one sample and wait for its score; lat=-1 on timeout.
  task automatic run_sample(
    input  logic [DW-1:0] s,
    input  bit            hold,
    output int            lat,
    output int            pl,
    output logic          an,
    output logic          dl,
    output int            dpc
  );
    int n = 0;
    int acc = -1;
    lat = -1;
    pl = -1;
    an = 1'bx;
    dl = 1'bx;
    dpc = 0;
    data_input = s;
    data_ready = 1'b1;
    while (n < 40) begin
      tick();
      n++;
      cfg_we = 1'b0;
      if (data_processed) begin
        dpc++;
        if (acc < 0) acc = n;
        if (!hold) data_ready = 1'b0;
      end
      if (score_valid) begin
        lat = n - acc;
        pl = int'(path_length);
        an = anomaly;
        dl = depth_limit;
        data_ready = 1'b0;
        break;
      end
    end
    data_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    data_ready = 1'b1;
    data_input = 8'h10;
    cfg_we = 1'b0;
    tick();
    tick();
    checks++;
    if ({data_processed, score_valid, anomaly,
         depth_limit, path_length} !== 8'h00) begin
      failures++;
      $display("FAIL reset_outputs got dp=%b sv=%b an=%b dl=%b pl=%0d want all 0",
               data_processed, score_valid, anomaly,
               depth_limit, path_length);
    end
    data_ready = 1'b0;
    reset = 1'b0;
    tick();
    checks++;
    if (data_processed !== 1'b0) begin
      failures++;
      $display("FAIL reset_no_accept got dp=%b want 0", data_processed);
    end
  endtask

  task automatic test_spec_table();
    int lat, pl, dpc;
    logic an, dl;
    load_std_table();
    run_sample(8'h10, 0, lat, pl, an, dl, dpc);
    checks++;
    if (lat !== 3 || pl !== 1 || an !== 1'b1 || dl !== 1'b0) begin
      failures++;
      $display("FAIL s10 got lat=%0d pl=%0d an=%b dl=%b want 3 1 1 0",
               lat, pl, an, dl);
    end
    run_sample(8'hF8, 0, lat, pl, an, dl, dpc);
    checks++;
    if (lat !== 5 || pl !== 3 || an !== 1'b0 || dl !== 1'b0) begin
      failures++;
      $display("FAIL sF8 got lat=%0d pl=%0d an=%b dl=%b want 5 3 0 0",
               lat, pl, an, dl);
    end
    run_sample(8'h80, 0, lat, pl, an, dl, dpc);
    checks++;
    if (lat !== 4 || pl !== 2 || an !== 1'b1 || dl !== 1'b0) begin
      failures++;
      $display("FAIL s80 got lat=%0d pl=%0d an=%b dl=%b want 4 2 1 0",
               lat, pl, an, dl);
    end
    tick();
    checks++;
    if (path_length !== 4'd2 || anomaly !== 1'b1) begin
      failures++;
      $display("FAIL hold got pl=%0d an=%b want 2 1",
               path_length, anomaly);
    end
  endtask

  task automatic test_depth_limit();
    int lat, pl, dpc;
    logic an, dl;
    write_node(0, 8'h80, 1, 7, 0);
    write_node(7, 8'h40, 7, 7, 0);
    run_sample(8'h90, 0, lat, pl, an, dl, dpc);
    checks++;
    if (lat !== MAXD + 2 || pl !== MAXD ||
        an !== 1'b0 || dl !== 1'b1) begin
      failures++;
      $display("FAIL depth_cap got lat=%0d pl=%0d an=%b dl=%b want %0d %0d 0 1",
               lat, pl, an, dl, MAXD + 2, MAXD);
    end
    load_std_table();
  endtask

  task automatic test_reset_mid_walk();
    int lat, pl, dpc;
    int seen = 0;
    logic an, dl;
    data_input = 8'hF8;
    data_ready = 1'b1;
    tick();
    data_ready = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (score_valid) seen++;
    end
    checks++;
    if (seen !== 0 || path_length !== 4'd0 ||
        anomaly !== 1'b0 || depth_limit !== 1'b0) begin
      failures++;
      $display("FAIL abort got sv_cnt=%0d pl=%0d an=%b dl=%b want 0 0 0 0",
               seen, path_length, anomaly, depth_limit);
    end
    run_sample(8'h10, 0, lat, pl, an, dl, dpc);
    checks++;
    if (lat !== 3 || pl !== 1 || an !== 1'b1) begin
      failures++;
      $display("FAIL after_abort got lat=%0d pl=%0d an=%b want 3 1 1",
               lat, pl, an);
    end
  endtask

  task automatic test_cfg_during_walk();
    int lat, pl, dpc;
    logic an, dl;
    logic [AW-1:0] sv_addr;
    data_input = 8'h10;
    data_ready = 1'b1;
    tick();
    data_ready = 1'b0;
    // Write lands on WALK edges only; model keeps n1 a leaf.
    cfg_we = 1'b1;
    cfg_addr = 4'd1;
    cfg_threshold = 8'h00;
    cfg_left = 4'd3;
    cfg_right = 4'd3;
    cfg_leaf = 1'b0;
    sv_addr = cfg_addr;
    tick();
    tick();
    cfg_we = 1'b0;
    pl = -1;
    for (int i = 0; i < 10; i++) begin
      if (score_valid) begin
        pl = int'(path_length);
        break;
      end
      tick();
    end
    checks++;
    if (pl !== 1) begin
      failures++;
      $display("FAIL cfg_in_walk n%0d got pl=%0d want 1", sv_addr, pl);
    end
    run_sample(8'h10, 0, lat, pl, an, dl, dpc);
    checks++;
    if (pl !== 1 || lat !== 3) begin
      failures++;
      $display("FAIL cfg_discarded got pl=%0d lat=%0d want 1 3", pl, lat);
    end
    run_sample(8'hF8, 1, lat, pl, an, dl, dpc);
    checks++;
    if (dpc !== 1 || pl !== 3) begin
      failures++;
      $display("FAIL held_ready got dp_cnt=%0d pl=%0d want 1 3", dpc, pl);
    end
  endtask

  task automatic test_write_and_accept();
    int lat, pl, dpc, epl;
    logic an, dl, edl;
    stage_node(1, 8'h00, 3, 3, 0);
    ref_walk(8'h10, epl, edl);
    run_sample(8'h10, 0, lat, pl, an, dl, dpc);
    checks++;
    if (pl !== epl || lat !== epl + 2 || pl !== 2) begin
      failures++;
      $display("FAIL wr_accept got pl=%0d lat=%0d want %0d %0d",
               pl, lat, epl, epl + 2);
    end
    write_node(1, 0, 0, 0, 1);
  endtask

  task automatic test_serial();
    int lat, pl, dpc;
    logic an, dl;
    logic [7:0] sh = 8'h00;
    logic [7:0] bits = 8'b11010101;
    for (int i = 7; i >= 0; i--) sh = {sh[6:0], bits[i]};
    run_sample(sh, 0, lat, pl, an, dl, dpc);
    checks++;
    if (pl !== 3 || an !== 1'b0 || dl !== 1'b0 || lat !== 5) begin
      failures++;
      $display("FAIL serial_d5 got pl=%0d an=%b dl=%b lat=%0d want 3 0 0 5",
               pl, an, dl, lat);
    end
  endtask

  task automatic test_random();
    int lat, pl, dpc, epl;
    logic an, dl, edl, ean;
    logic [DW-1:0] s;
    for (int t = 0; t < 4; t++) begin
      for (int a = 0; a < 16; a++)
        write_node(a, int'($urandom_range(0, 255)),
                   int'($urandom_range(0, 15)),
                   int'($urandom_range(0, 15)),
                   ($urandom_range(0, 3) == 0));
      for (int k = 0; k < 12; k++) begin
        s = DW'($urandom_range(0, 255));
        ref_walk(s, epl, edl);
        ean = (epl < ANOMD);
        run_sample(s, ($urandom_range(0, 1) == 1),
                   lat, pl, an, dl, dpc);
        checks++;
        if (pl !== epl || an !== ean || dl !== edl ||
            lat !== epl + 2 || dpc !== 1) begin
          failures++;
          $display("FAIL rand s=%h got pl=%0d an=%b dl=%b lat=%0d dp=%0d want %0d %b %b %0d 1",
                   s, pl, an, dl, lat, dpc, epl, ean, edl, epl + 2);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int n = 0;
    int dpc = 0;
    int svc = 0;
    int last = -10;
    int dbl = 0;
    load_std_table();
    data_input = 8'h10;
    data_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      n++;
      if (data_processed) begin
        if (last == n - 1) dbl++;
        last = n;
        dpc++;
      end
      if (score_valid) svc++;
    end
    data_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (score_valid) svc++;
    end
    checks++;
    if (dbl !== 0 || dpc !== 5 || svc !== 5) begin
      failures++;
      $display("FAIL b2b got dp=%0d sv=%0d dbl=%0d want 5 5 0",
               dpc, svc, dbl);
    end
  endtask

  initial begin
    reset = 1'b0;
    data_input = '0;
    data_ready = 1'b0;
    cfg_we = 1'b0;
    cfg_addr = '0;
    cfg_threshold = '0;
    cfg_left = '0;
    cfg_right = '0;
    cfg_leaf = 1'b0;
    test_reset();
    test_spec_table();
    test_depth_limit();
    test_reset_mid_walk();
    test_cfg_during_walk();
    test_write_and_accept();
    test_serial();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
